instr_fetch_unit: RTL and testbench

//   Instruction-fetch stage of the RISC-V core.
//   - Owns the program counter and issues word reads to instruction memory over a req/ack handshake.
//   - Buffers one fetched instruction plus its PC and hands it to decode over a valid/ready handshake.
//   - Redirect input (branch/jump/trap from execute) flushes the buffered instruction and kills any in-flight fetch.

---
 rtl/riscv_pkg.sv | 14 +
 rtl/fetch_out_buf.sv | 84 ++++++++
 rtl/instr_fetch_unit.sv | 157 +++++++++++++++
 tb/tb_instr_fetch_unit.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared fetch-stage types and constants.
// Imported by instr_fetch_unit and fetch_out_buf.
package riscv_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD
    } fetch_state_t;

endpackage

// File: rtl/fetch_out_buf.sv
// One-entry fetch-to-decode holding register (valid, pc, instr).
// FETCH_MISALIGN_TRAP_EN adds a misalign flag travelling with the entry.
module fetch_out_buf #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            flush,
    input  logic            unload,
    input  logic [XLEN-1:0] load_pc,
    input  logic [31:0]     load_instr,
`ifdef FETCH_MISALIGN_TRAP_EN
    input  logic            load_misalign,
    output logic            buf_misalign,
`endif
    output logic            buf_valid,
    output logic [XLEN-1:0] buf_pc,
    output logic [31:0]     buf_instr
);
    import riscv_pkg::*;

    logic            valid_q, valid_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     instr_q, instr_d;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic            mis_q, mis_d;
`endif

    // flush beats load so a redirect always empties the entry
    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        instr_d = instr_q;
`ifdef FETCH_MISALIGN_TRAP_EN
        mis_d   = mis_q;
`endif
        if (flush) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
`ifdef FETCH_MISALIGN_TRAP_EN
            mis_d   = 1'b0;
`endif
        end else if (load) begin
            valid_d = 1'b1;
            pc_d    = load_pc;
            instr_d = load_instr;
`ifdef FETCH_MISALIGN_TRAP_EN
            mis_d   = load_misalign;
`endif
        end else if (unload) begin
            valid_d = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            mis_d   = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= NOP_INSTR;
`ifdef FETCH_MISALIGN_TRAP_EN
            mis_q   <= 1'b0;
`endif
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
`ifdef FETCH_MISALIGN_TRAP_EN
            mis_q   <= mis_d;
`endif
        end
    end

    assign buf_valid = valid_q;
    assign buf_pc    = pc_q;
    assign buf_instr = instr_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign buf_misalign = mis_q;
`endif

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, imem req/ack, one-entry decode buffer.
// FETCH_MISALIGN_TRAP_EN adds if_misalign and misaligned-redirect traps.
module instr_fetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [31:0]     if_instr,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic            if_misalign,
`endif
    input  logic            id_ready
);
    import riscv_pkg::*;

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_addr_q, req_addr_d;
    logic            kill_q, kill_d;

    logic [XLEN-1:0] pc_inc;
    logic [XLEN-1:0] tgt;
    logic [XLEN-1:0] ld_pc;
    logic [31:0]     ld_instr;
    logic            buf_load;
    logic            buf_flush;
    logic            drain;
    logic            space;
    logic            fire;
    logic            pend;
    logic            trap;
    logic            pc_bad;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic            ld_mis;
    assign trap      = redirect_pc[1:0] != 2'b00;
    assign pc_bad    = pc_q[1:0] != 2'b00;
    assign tgt       = redirect_pc;
    assign imem_addr = req_addr_q;
    assign ld_mis    = redirect;
`else
    logic            unused_rpc_lo;
    assign unused_rpc_lo = ^redirect_pc[1:0];
    assign trap      = 1'b0;
    assign pc_bad    = 1'b0;
    assign tgt       = {redirect_pc[XLEN-1:2], 2'b00};
    assign imem_addr = {req_addr_q[XLEN-1:2], 2'b00};
`endif

    assign pc_inc = pc_q + XLEN'(4);
    assign drain  = if_valid && id_ready && !stall;
    assign space  = !if_valid || drain;

    // a full buffer only requests when it drains the same cycle
    assign imem_req = (state_q == FETCH) && (kill_q || space);
    assign fire     = imem_req && imem_ack;
    assign pend     = imem_req && !imem_ack;

    // only a redirect loads the trap entry; normal loads take memory data
    assign ld_pc    = redirect ? tgt : req_addr_q;
    assign ld_instr = redirect ? NOP_INSTR : imem_rdata;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        kill_d     = kill_q;
        buf_load   = 1'b0;
        buf_flush  = 1'b0;
        if (redirect) begin
            pc_d       = tgt;
            req_addr_d = pend ? req_addr_q : tgt;
            kill_d     = pend;
            if (trap) begin
                buf_load = 1'b1;
                state_d  = pend ? FETCH : HOLD;
            end else begin
                buf_flush = 1'b1;
                state_d   = FETCH;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d    = FETCH;
                    req_addr_d = pc_q;
                end
                FETCH: begin
                    if (fire && kill_q) begin
                        kill_d     = 1'b0;
                        req_addr_d = pc_q;
                        state_d    = pc_bad ? HOLD : FETCH;
                    end else if (fire) begin
                        buf_load   = 1'b1;
                        pc_d       = pc_inc;
                        req_addr_d = pc_inc;
                        state_d    = (id_ready && !stall) ? FETCH : HOLD;
                    end else if (!imem_req) begin
                        state_d = HOLD;
                    end
                end
                HOLD: begin
                    if (drain) begin
                        req_addr_d = pc_q;
                        if (!pc_bad) begin
                            state_d = FETCH;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            req_addr_q <= '0;
            kill_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            kill_q     <= kill_d;
        end
    end

    fetch_out_buf #(
        .XLEN(XLEN)
    ) u_out_buf (
        .clk          (clk),
        .rst          (rst),
        .load         (buf_load),
        .flush        (buf_flush),
        .unload       (drain),
        .load_pc      (ld_pc),
        .load_instr   (ld_instr),
`ifdef FETCH_MISALIGN_TRAP_EN
        .load_misalign(ld_mis),
        .buf_misalign (if_misalign),
`endif
        .buf_valid    (if_valid),
        .buf_pc       (if_pc),
        .buf_instr    (if_instr)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a fixed-latency memory model.
// Memory returns rdata = addr ^ 32'hC0DE0000.
module tb_instr_fetch_unit;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] SALT = 32'hC0DE_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        if_misalign;
`endif
    logic        id_ready;

    int ack_delay = 0;
    int wait_cnt  = 0;
    int n_chk     = 0;
    int n_pass    = 0;

    always #5 clk = ~clk;

    assign imem_ack   = imem_req && (wait_cnt >= ack_delay);
    assign imem_rdata = imem_addr ^ SALT;

    always @(posedge clk) begin
        if (!imem_req || imem_ack) wait_cnt <= 0;
        else wait_cnt <= wait_cnt + 1;
    end

    instr_fetch_unit dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .if_valid   (if_valid),
        .if_pc      (if_pc),
        .if_instr   (if_instr),
`ifdef FETCH_MISALIGN_TRAP_EN
        .if_misalign(if_misalign),
`endif
        .id_ready   (id_ready)
    );

    task automatic do_reset(input logic ready, input int delay);
        @(negedge clk);
        rst         = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        id_ready    = ready;
        ack_delay   = delay;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_chk++;
        if (imem_req !== 1'b0) $display("FAIL rst_req got %b want 0", imem_req);
        else n_pass++;
        n_chk++;
        if (if_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", if_valid);
        else n_pass++;
        n_chk++;
        if (if_pc !== 32'h0) $display("FAIL rst_pc got %h want 0", if_pc);
        else n_pass++;
        n_chk++;
        if (if_instr !== NOP) $display("FAIL rst_instr got %h want %h", if_instr, NOP);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        do_reset(1'b1, 0);
        @(negedge clk);
        n_chk++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0)
            $display("FAIL b2b_first req=%b addr=%h want 1/0", imem_req, imem_addr);
        else n_pass++;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            exp = 32'(4 * (i - 1));
            n_chk++;
            if (if_valid !== 1'b1 || if_pc !== exp)
                $display("FAIL b2b_pc[%0d] v=%b pc=%h want 1/%h", i, if_valid, if_pc, exp);
            else n_pass++;
            n_chk++;
            if (if_instr !== (exp ^ SALT))
                $display("FAIL b2b_instr[%0d] got %h want %h", i, if_instr, exp ^ SALT);
            else n_pass++;
            n_chk++;
            if (imem_req !== 1'b1 || imem_addr !== exp + 32'h4)
                $display("FAIL b2b_addr[%0d] req=%b addr=%h want 1/%h",
                         i, imem_req, imem_addr, exp + 32'h4);
            else n_pass++;
        end
        rst = 1'b0;
        #1;
        n_chk++;
        if (imem_req !== 1'b0 || if_valid !== 1'b0)
            $display("FAIL async_rst req=%b valid=%b want 0/0", imem_req, if_valid);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        do_reset(1'b0, 0);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_chk++;
            if (imem_req !== 1'b0 || if_valid !== 1'b1 || if_pc !== 32'h0)
                $display("FAIL bp_hold[%0d] req=%b v=%b pc=%h want 0/1/0",
                         k, imem_req, if_valid, if_pc);
            else n_pass++;
        end
        id_ready = 1'b1;
        @(negedge clk);
        n_chk++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h4 || if_valid !== 1'b0)
            $display("FAIL bp_resume req=%b addr=%h v=%b want 1/4/0",
                     imem_req, imem_addr, if_valid);
        else n_pass++;
        @(negedge clk);
        n_chk++;
        if (if_valid !== 1'b1 || if_pc !== 32'h4)
            $display("FAIL bp_capture v=%b pc=%h want 1/4", if_valid, if_pc);
        else n_pass++;
    endtask

    task automatic test_redirect_kill();
        bit got;
        do_reset(1'b1, 3);
        @(negedge clk);
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            redirect = 1'b0;
            n_chk++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h0 || if_valid !== 1'b0)
                $display("FAIL kill_wait[%0d] req=%b addr=%h v=%b want 1/0/0",
                         k, imem_req, imem_addr, if_valid);
            else n_pass++;
        end
        @(negedge clk);
        n_chk++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h100 || if_valid !== 1'b0)
            $display("FAIL kill_next req=%b addr=%h v=%b want 1/100/0",
                     imem_req, imem_addr, if_valid);
        else n_pass++;
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk);
            if (if_valid === 1'b1) got = 1'b1;
        end
        n_chk++;
        if (!got || if_pc !== 32'h100 || if_instr !== (32'h100 ^ SALT))
            $display("FAIL kill_capture got=%b pc=%h instr=%h want 1/100/%h",
                     got, if_pc, if_instr, 32'h100 ^ SALT);
        else n_pass++;
    endtask

    task automatic test_wrap();
        do_reset(1'b1, 0);
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        @(negedge clk);
        redirect = 1'b0;
        n_chk++;
        if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC)
            $display("FAIL wrap_top req=%b addr=%h want 1/fffffffc", imem_req, imem_addr);
        else n_pass++;
        @(negedge clk);
        n_chk++;
        if (imem_addr !== 32'h0 || if_pc !== 32'hFFFF_FFFC)
            $display("FAIL wrap_zero addr=%h pc=%h want 0/fffffffc", imem_addr, if_pc);
        else n_pass++;
    endtask

    task automatic test_stall_redirect();
        do_reset(1'b1, 0);
        repeat (3) @(negedge clk);
        stall       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        #1;
        n_chk++;
        if (imem_req !== 1'b0)
            $display("FAIL stall_noreq got %b want 0", imem_req);
        else n_pass++;
        @(negedge clk);
        redirect = 1'b0;
        n_chk++;
        if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h40)
            $display("FAIL stall_redir v=%b req=%b addr=%h want 0/1/40",
                     if_valid, imem_req, imem_addr);
        else n_pass++;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_chk++;
            if (if_valid !== 1'b1 || if_pc !== 32'h40 || imem_req !== 1'b0)
                $display("FAIL stall_hold[%0d] v=%b pc=%h req=%b want 1/40/0",
                         k, if_valid, if_pc, imem_req);
            else n_pass++;
        end
        stall = 1'b0;
        @(negedge clk);
        n_chk++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h44)
            $display("FAIL stall_resume req=%b addr=%h want 1/44", imem_req, imem_addr);
        else n_pass++;
    endtask

`ifdef FETCH_MISALIGN_TRAP_EN
    task automatic test_misalign();
        do_reset(1'b0, 0);
        @(negedge clk);
        redirect    = 1'b1;
        redirect_pc = 32'h42;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            redirect = 1'b0;
            n_chk++;
            if (if_valid !== 1'b1 || if_misalign !== 1'b1 || if_pc !== 32'h42
                || if_instr !== NOP || imem_req !== 1'b0)
                $display("FAIL mis_trap[%0d] v=%b m=%b pc=%h i=%h req=%b want 1/1/42/13/0",
                         k, if_valid, if_misalign, if_pc, if_instr, imem_req);
            else n_pass++;
        end
        id_ready = 1'b1;
        @(negedge clk);
        n_chk++;
        if (if_valid !== 1'b0 || if_misalign !== 1'b0 || imem_req !== 1'b0)
            $display("FAIL mis_clear v=%b m=%b req=%b want 0/0/0",
                     if_valid, if_misalign, imem_req);
        else n_pass++;
    endtask
`endif

    initial begin
        rst         = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        id_ready    = 1'b0;
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_redirect_kill();
        test_wrap();
        test_stall_redirect();
`ifdef FETCH_MISALIGN_TRAP_EN
        test_misalign();
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
